div_operand_sequencer: RTL and testbench
========================================

Name: div_operand_sequencer

Overview:
- Front-end stage placed directly upstream of the 10-by-5 restoring divider.
- Accepts operand pairs over a valid/ready handshake and screens them for divide-by-zero and quotient overflow.
- Launches the divider with a one-cycle start pulse, waits for its ready, captures Q/R, and presents a tagged result over a valid/ready output handshake.
- Includes a watchdog so a hung divider cannot stall the pipeline.

Parameters:
- DW_DVD, 10, dividend width; must equal 2*DW_DVS.
- DW_DVS, 5, divisor, quotient and remainder width.
- TIMEOUT, 31, maximum cycles spent in WAIT_DONE before a timeout error; range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the clk rising edge; 0 = reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept an operand pair.
- in_dividend  input  DW_DVD  dividend.
- in_divisor  input  DW_DVS  divisor.
- div_start  output  1  one-cycle start pulse to the divider.
- div_dividend  output  DW_DVD  registered dividend to the divider.
- div_divisor  output  DW_DVS  registered divisor to the divider.
- div_ready  input  1  divider idle/done flag.
- div_q  input  DW_DVS  divider quotient.
- div_r  input  DW_DVS  divider remainder.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_q  output  DW_DVS  quotient.
- out_r  output  DW_DVS  remainder.
- out_err  output  2  result code: 00 ok, 01 divide-by-zero, 10 overflow, 11 timeout.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE; in_ready=1 in the following cycle.
  - div_start=0, out_valid=0, out_q=0, out_r=0, out_err=00.
  - div_dividend=0, div_divisor=0, watchdog counter=0.
  - Reset wins over every other event in every state. A pending result is discarded, and div_start is never emitted in the reset cycle.
- in_ready=1 only in IDLE. All outputs are registered.
- IDLE: on in_valid&in_ready, latch the operands into div_dividend/div_divisor and go to CHECK.
- CHECK (one cycle minimum). Priority order:
  - divisor==0: set out_err=01, out_q=all-ones, out_r=0; go to RESP.
  - else dividend[DW_DVD-1:DW_DVS] >= divisor (quotient does not fit): set out_err=10, out_q=all-ones, out_r=0; go to RESP.
  - else div_ready==0 (divider still busy): stay in CHECK.
  - else assert div_start for exactly one cycle; go to WAIT_BUSY.
  - Error paths never assert div_start.
- WAIT_BUSY: exactly one cycle; div_ready is ignored; clear the watchdog; go to WAIT_DONE.
- WAIT_DONE: watchdog increments each cycle.
  - First cycle with div_ready=1: capture div_q/div_r into out_q/out_r, set out_err=00; go to RESP.
  - If the watchdog reaches TIMEOUT with div_ready still 0: set out_err=11, out_q=all-ones, out_r=0; go to RESP.
  - If div_ready=1 in the same cycle the watchdog hits TIMEOUT, the capture takes priority (ok result).
- RESP:
  - out_valid=1.
  - out_q, out_r and out_err stay stable while out_ready=0.
  - On out_ready=1: out_valid drops next cycle; go to IDLE.
- Latency, ok path with a ready divider and out_ready=1: accept at cycle 0, CHECK at 1, div_start at 2, then divider latency, then out_valid one cycle after div_ready is seen.
- Error path latency: out_valid at cycle 2 after accept.
- div_dividend/div_divisor stay constant from accept until return to IDLE.

Optional Feature:
- Macro: DIV_OPERAND_SEQUENCER_STATS_EN.
- Defined:
  - Adds outputs stat_ops[7:0] (results handed off with out_err=00) and stat_errs[7:0] (results handed off with out_err!=00).
  - Both increment on the out_valid&out_ready cycle, saturate at 255, and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Normal division: dividend=100, divisor=7, divider model returns after 6 cycles -> exactly one div_start pulse; out_q=14, out_r=2, out_err=00.
- Divide-by-zero: dividend=50, divisor=0 -> no div_start; out_valid two cycles after accept; out_err=01, out_q=31, out_r=0.
- Overflow: dividend=1000, divisor=5 (upper bits 31>=5) -> no div_start; out_err=10. Also dividend=159, divisor=5 (upper bits 4<5) -> launched, out_q=31, out_r=4, err=00.
- Timeout: div_ready held 0 after start -> out_err=11 exactly TIMEOUT=31 cycles after entering WAIT_DONE; a new operand is accepted afterwards.
- Backpressure and busy: out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Separately, div_ready=0 at CHECK for 3 cycles -> div_start delayed until div_ready=1.
- Reset mid-operation: rst=0 during WAIT_DONE -> next cycle state=IDLE, out_valid=0, in_ready=1, no stale result. With STATS_EN: counts cleared, saturate at 255 after 260 ok ops.

Source files
------------

// File: rtl/div_operand_sequencer.sv
// Screens operand pairs for divide-by-zero/overflow, then runs the restoring divider with a watchdog.
// Latency: error result 2 cycles after accept; ok result 1 cycle after the divider reports done.
// Backpressure: in_ready only in IDLE; the result is held until out_ready. Option: DIV_OPERAND_SEQUENCER_STATS_EN.
module div_operand_sequencer #(
    parameter int DW_DVD  = 10,
    parameter int DW_DVS  = 5,
    parameter int TIMEOUT = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW_DVD-1:0] in_dividend,
    input  logic [DW_DVS-1:0] in_divisor,
    output logic              div_start,
    output logic [DW_DVD-1:0] div_dividend,
    output logic [DW_DVS-1:0] div_divisor,
    input  logic              div_ready,
    input  logic [DW_DVS-1:0] div_q,
    input  logic [DW_DVS-1:0] div_r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW_DVS-1:0] out_q,
    output logic [DW_DVS-1:0] out_r,
    output logic [1:0]        out_err
`ifdef DIV_OPERAND_SEQUENCER_STATS_EN
    ,
    output logic [7:0]        stat_ops,
    output logic [7:0]        stat_errs
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    localparam logic [7:0]        WD_LAST = 8'(TIMEOUT - 1);
    localparam logic [DW_DVS-1:0] ALL1    = '1;

    state_t     state;
    logic [7:0] wdog;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            out_valid    <= 1'b0;
            out_q        <= '0;
            out_r        <= '0;
            out_err      <= 2'b00;
            wdog         <= '0;
        end else begin
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        div_dividend <= in_dividend;
                        div_divisor  <= in_divisor;
                        in_ready     <= 1'b0;
                        state        <= CHECK;
                    end
                end
                CHECK: begin
                    // Quotient fits in DW_DVS bits only if the upper dividend half is below the divisor.
                    if (div_divisor == '0) begin
                        out_err   <= 2'b01;
                        out_q     <= ALL1;
                        out_r     <= '0;
                        out_valid <= 1'b1;
                        state     <= RESP;
                    end else if (div_dividend[DW_DVD-1:DW_DVS] >= div_divisor) begin
                        out_err   <= 2'b10;
                        out_q     <= ALL1;
                        out_r     <= '0;
                        out_valid <= 1'b1;
                        state     <= RESP;
                    end else if (div_ready) begin
                        div_start <= 1'b1;
                        state     <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // The divider's ready may still reflect the previous op here.
                    wdog  <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (div_ready) begin
                        out_q     <= div_q;
                        out_r     <= div_r;
                        out_err   <= 2'b00;
                        out_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wdog == WD_LAST) begin
                        out_err   <= 2'b11;
                        out_q     <= ALL1;
                        out_r     <= '0;
                        out_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef DIV_OPERAND_SEQUENCER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else if (out_valid && out_ready) begin
            if (out_err == 2'b00) begin
                if (stat_ops != 8'hff) stat_ops <= stat_ops + 8'd1;
            end else begin
                if (stat_errs != 8'hff) stat_errs <= stat_errs + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_div_operand_sequencer.sv
// Bench for div_operand_sequencer with a behavioural divider model and a result scoreboard.
module tb_div_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [9:0] in_dividend;
    logic [4:0] in_divisor;
    logic       div_start;
    logic [9:0] div_dividend;
    logic [4:0] div_divisor;
    logic       div_ready;
    logic [4:0] div_q, div_r;
    logic       out_valid, out_ready;
    logic [4:0] out_q, out_r;
    logic [1:0] out_err;
`ifdef DIV_OPERAND_SEQUENCER_STATS_EN
    logic [7:0] stat_ops, stat_errs;
`endif

    div_operand_sequencer #(.DW_DVD(10), .DW_DVS(5), .TIMEOUT(31)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_ready(div_ready), .div_q(div_q), .div_r(div_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_err(out_err)
`ifdef DIV_OPERAND_SEQUENCER_STATS_EN
        , .stat_ops(stat_ops), .stat_errs(stat_errs)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          start_cnt = 0;
    int          e_ops = 0;
    int          e_errs = 0;
    logic [11:0] sb[$];

    // Divider model: busy m_lat cycles after start; m_hang keeps it busy indefinitely.
    int         m_lat = 6;
    int         m_cnt = 0;
    bit         m_hang = 0;
    bit         m_force_busy = 0;
    logic       m_busy = 1'b0;
    logic [4:0] m_q = '0, m_r = '0;

    always @(posedge clk) begin
        if (div_start) start_cnt <= start_cnt + 1;
        if (!rst) begin
            m_busy <= 1'b0;
        end else if (div_start) begin
            m_busy <= 1'b1;
            m_cnt  <= m_lat;
            m_q    <= 5'(int'(div_dividend) / int'(div_divisor));
            m_r    <= 5'(int'(div_dividend) % int'(div_divisor));
        end else if (m_busy && !m_hang) begin
            if (m_cnt <= 1) m_busy <= 1'b0;
            else m_cnt <= m_cnt - 1;
        end
    end

    assign div_ready = !m_busy && !m_force_busy;
    assign div_q = m_q;
    assign div_r = m_r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] f_exp(input logic [9:0] dvd, input logic [4:0] dvs);
        int a, b;
        a = int'(dvd);
        b = int'(dvs);
        if (b == 0) return {5'h1f, 5'h00, 2'b01};
        if ((a >> 5) >= b) return {5'h1f, 5'h00, 2'b10};
        return {5'(a / b), 5'(a % b), 2'b00};
    endfunction

    task automatic run_op(input logic [9:0] dvd, input logic [4:0] dvs, input logic [11:0] exp,
                          input int exp_starts, input int exp_lat, input int hold, input int busy_cyc);
        int s0, n;
        sb.push_back(exp);
        s0 = start_cnt;
        if (busy_cyc > 0) m_force_busy = 1;
        out_ready   = (hold == 0);
        in_dividend = dvd;
        in_divisor  = dvs;
        in_valid    = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        chk("accept", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        if (busy_cyc > 0) begin
            repeat (busy_cyc) begin @(negedge clk); n++; end
            chk("busy_no_start", 32'(start_cnt - s0), 32'd0);
            m_force_busy = 0;
        end
        while (!out_valid && n < 300) begin @(negedge clk); n++; end
        chk("out_valid", 32'(out_valid), 32'd1);
        if (exp_lat >= 0) chk("latency", 32'(n), 32'(exp_lat));
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                chk("hold_data", 32'({out_q, out_r, out_err}), 32'(sb[0]));
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
        end
        chk("result", 32'({out_q, out_r, out_err}), 32'(sb.pop_front()));
        chk("div_dividend", 32'(div_dividend), 32'(dvd));
        chk("div_divisor", 32'(div_divisor), 32'(dvs));
        if (exp[1:0] == 2'b00) begin
            if (e_ops < 255) e_ops++;
        end else begin
            if (e_errs < 255) e_errs++;
        end
        @(negedge clk);
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("start_count", 32'(start_cnt - s0), 32'(exp_starts));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got hang expected completion");
        $fatal(1);
    end

    initial begin
        logic [9:0]  rd;
        logic [4:0]  rs;
        logic [11:0] re;
        int          n;
        rst = 1'b0; in_valid = 1'b0; in_dividend = '0; in_divisor = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_div_start", 32'(div_start), 32'd0);
        chk("rst_out", 32'({out_q, out_r, out_err}), 32'd0);
        chk("rst_div_ops", 32'({div_dividend, div_divisor}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases.
        m_lat = 6;
        run_op(10'd100, 5'd7, {5'd14, 5'd2, 2'b00}, 1, 10, 0, 0);
        run_op(10'd50, 5'd0, {5'd31, 5'd0, 2'b01}, 0, 2, 0, 0);
        run_op(10'd1000, 5'd5, {5'd31, 5'd0, 2'b10}, 0, 2, 0, 0);
        run_op(10'd159, 5'd5, {5'd31, 5'd4, 2'b00}, 1, 10, 0, 0);
        m_hang = 1;
        run_op(10'd200, 5'd9, {5'd31, 5'd0, 2'b11}, 1, 34, 0, 0);
        m_hang = 0;
        run_op(10'd60, 5'd7, {5'd8, 5'd4, 2'b00}, 1, -1, 0, 0);
        // Ready on the watchdog's final cycle wins; one cycle later is a timeout.
        m_lat = 30;
        run_op(10'd45, 5'd4, {5'd11, 5'd1, 2'b00}, 1, 34, 0, 0);
        m_lat = 31;
        run_op(10'd45, 5'd4, {5'd31, 5'd0, 2'b11}, 1, 34, 0, 0);
        m_lat = 6;
        run_op(10'd77, 5'd3, {5'd25, 5'd2, 2'b00}, 1, 10, 5, 0);
        run_op(10'd300, 5'd11, {5'd27, 5'd3, 2'b00}, 1, -1, 0, 3);

        for (int i = 0; i < 10; i++) begin
            rd = 10'($urandom_range(0, 1023));
            rs = 5'($urandom_range(0, 31));
            m_lat = $urandom_range(1, 8);
            re = f_exp(rd, rs);
            run_op(rd, rs, re, (re[1:0] == 2'b00) ? 1 : 0,
                   (re[1:0] == 2'b00) ? 4 + m_lat : 2, 0, 0);
        end

        // Reset during WAIT_DONE discards the in-flight op.
        m_hang = 1;
        in_dividend = 10'd90; in_divisor = 5'd13; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_hang = 0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out", 32'({out_q, out_r, out_err}), 32'd0);
        e_ops = 0;
        e_errs = 0;
`ifdef DIV_OPERAND_SEQUENCER_STATS_EN
        chk("midrst_stat_ops", 32'(stat_ops), 32'd0);
        chk("midrst_stat_errs", 32'(stat_errs), 32'd0);
`endif
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("midrst_no_stale", 32'(n), 32'd0);
        m_lat = 3;
        run_op(10'd90, 5'd13, {5'd6, 5'd12, 2'b00}, 1, 7, 0, 0);
        run_op(10'd12, 5'd0, {5'd31, 5'd0, 2'b01}, 0, 2, 0, 0);

`ifdef DIV_OPERAND_SEQUENCER_STATS_EN
        chk("stat_ops", 32'(stat_ops), 32'(e_ops));
        chk("stat_errs", 32'(stat_errs), 32'(e_errs));
        m_lat = 1;
        for (int i = 0; i < 260; i++) begin
            run_op(10'd33, 5'd2, {5'd16, 5'd1, 2'b00}, 1, 5, 0, 0);
        end
        chk("stat_ops_sat", 32'(stat_ops), 32'd255);
        chk("stat_errs_final", 32'(stat_errs), 32'(e_errs));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
